seq_detector: RTL and testbench

//  Parametrised Moore-style serial pattern detector with a stretched output pulse.

---
 rtl/seq_detector_if.sv | 19 +
 rtl/seq_detector.sv | 105 ++++++++++
 tb/tb_seq_detector.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_detector_if.sv
// Serial-sample bus of the pattern detector: qualified input bit and clear towards
// the detector, detection pulse and match statistics back from it.
interface seq_detector_if #(
   parameter int CNT_W = 8
);
   logic             en;
   logic             in;
   logic             clr;
   logic             smOut;
   logic             armed;
   logic [CNT_W-1:0] match_cnt;
   logic             sat;

   // master drives samples (conditioning logic), slave is the detector
   modport master (output en, output in, output clr,
                   input smOut, input armed, input match_cnt, input sat);
   modport slave  (input en, input in, input clr,
                   output smOut, output armed, output match_cnt, output sat);
endinterface

// File: rtl/seq_detector.sv
// Moore-style serial pattern detector: matches the last LEN accepted bits against
// PATTERN, stretches each hit into a PULSE_W-cycle pulse and counts hits (saturating).
module seq_detector #(
   parameter int             LEN     = 4,
   parameter logic [LEN-1:0] PATTERN = 4'b1011,
   parameter bit             OVERLAP = 1'b1,
   parameter int             PULSE_W = 1,
   parameter int             CNT_W   = 8
) (
   input  logic         clk,
   input  logic         rst,
   seq_detector_if.slave bus
);
   localparam int FILL_W = $clog2(LEN + 1);
   localparam int PW_W   = $clog2(PULSE_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic {S_FILL, S_ARMED} state_e;

   state_e              state_q, state_d;
   logic [FILL_W-1:0]   fill_q, fill_d;
   // only the LEN-1 newest bits are kept; the oldest bit of a window is never needed later
   logic [LEN-2:0]      hist_q, hist_d;
   logic [PW_W-1:0]     pulse_q, pulse_d;
   logic                smout_q, smout_d;
   logic                armed_q, armed_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                sat_q, sat_d;

   logic [LEN-1:0]      window;
   logic                match;

   assign window = {hist_q, bus.in};
   // the filling sample itself may complete a match
   assign match  = bus.en && (window == PATTERN) &&
                   ((state_q == S_ARMED) || (fill_q == FILL_W'(LEN - 1)));

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      hist_d  = hist_q;
      pulse_d = pulse_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;

      if (bus.en) begin
         hist_d = window[LEN-2:0];
         if (fill_q != FILL_W'(LEN)) fill_d = fill_q + 1'b1;
      end

      case (state_q)
         S_FILL:  if (bus.en && (fill_q == FILL_W'(LEN - 1))) state_d = S_ARMED;
         S_ARMED: state_d = S_ARMED;
         default: state_d = S_FILL;
      endcase

      if (match && !OVERLAP) begin
         state_d = S_FILL;
         fill_d  = '0;
         hist_d  = '0;
      end

      // a new hit while stretching restarts the full pulse width
      if (match)                pulse_d = PW_W'(PULSE_W);
      else if (pulse_q != '0)   pulse_d = pulse_q - 1'b1;

      if (bus.clr) begin
         cnt_d = '0;
         sat_d = 1'b0;
      end else begin
         if (match && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
         if (cnt_d == CNT_MAX)            sat_d = 1'b1;
      end

      smout_d = (pulse_d != '0);
      armed_d = (state_d == S_ARMED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FILL;
         fill_q  <= '0;
         hist_q  <= '0;
         pulse_q <= '0;
         smout_q <= 1'b0;
         armed_q <= 1'b0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         hist_q  <= hist_d;
         pulse_q <= pulse_d;
         smout_q <= smout_d;
         armed_q <= armed_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   assign bus.smOut     = smout_q;
   assign bus.armed     = armed_q;
   assign bus.match_cnt = cnt_q;
   assign bus.sat       = sat_q;
endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: three configurations share one input stream and are
// compared cycle by cycle against a bit-window reference model.
module tb_seq_detector;
   localparam int NI = 3;
   // instance a: defaults; b: non-overlapping, wide pulse, 2-bit count; c: 5-bit pattern
   localparam int P_LEN  [NI] = '{4, 4, 5};
   localparam int P_PAT  [NI] = '{4'b1011, 4'b1011, 5'b10010};
   localparam int P_OVL  [NI] = '{1, 0, 1};
   localparam int P_PW   [NI] = '{1, 4, 2};
   localparam int P_CNTW [NI] = '{8, 2, 3};

   logic clk, rst, en, din, clr;
   int   n_checks, n_fail;

   seq_detector_if #(.CNT_W(8)) if_a ();
   seq_detector_if #(.CNT_W(2)) if_b ();
   seq_detector_if #(.CNT_W(3)) if_c ();

   assign if_a.en = en;  assign if_a.in = din;  assign if_a.clr = clr;
   assign if_b.en = en;  assign if_b.in = din;  assign if_b.clr = clr;
   assign if_c.en = en;  assign if_c.in = din;  assign if_c.clr = clr;

   seq_detector #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .PULSE_W(1), .CNT_W(8))
      u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
   seq_detector #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .PULSE_W(4), .CNT_W(2))
      u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
   seq_detector #(.LEN(5), .PATTERN(5'b10010), .OVERLAP(1'b1), .PULSE_W(2), .CNT_W(3))
      u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

   // clock/reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model: count of valid history bits, the numeric value of the window,
   // remaining pulse cycles and the hit count
   int m_fill [NI];
   int m_win  [NI];
   int m_pulse[NI];
   int m_cnt  [NI];
   bit m_sat  [NI];

   // scoreboard: {smOut, armed, sat, match_cnt[7:0]} expected after each edge
   logic [10:0] exp_a_q[$];
   logic [10:0] exp_b_q[$];
   logic [10:0] exp_c_q[$];

   task automatic model_step(input int k, input bit r, input bit e, input bit d, input bit c);
      int len, mask, cmax, w;
      bit hit;
      logic [10:0] ev;
      len  = P_LEN[k];
      mask = (1 << len) - 1;
      cmax = (1 << P_CNTW[k]) - 1;
      hit  = 1'b0;
      if (r) begin
         m_fill[k] = 0; m_win[k] = 0; m_pulse[k] = 0; m_cnt[k] = 0; m_sat[k] = 1'b0;
      end else begin
         if (e) begin
            w = ((m_win[k] * 2) + int'(d)) & mask;
            hit = (w == P_PAT[k]) && (m_fill[k] >= len - 1);
            m_win[k]  = w;
            m_fill[k] = (m_fill[k] < len) ? m_fill[k] + 1 : len;
            if (hit && P_OVL[k] == 0) begin
               m_fill[k] = 0;
               m_win[k]  = 0;
            end
         end
         if (hit) m_pulse[k] = P_PW[k];
         else if (m_pulse[k] > 0) m_pulse[k]--;
         if (c) begin
            m_cnt[k] = 0;
            m_sat[k] = 1'b0;
         end else begin
            if (hit && m_cnt[k] < cmax) m_cnt[k]++;
            if (m_cnt[k] == cmax) m_sat[k] = 1'b1;
         end
      end
      ev = {(m_pulse[k] > 0), (m_fill[k] == len), m_sat[k], 8'(m_cnt[k])};
      case (k)
         0:       exp_a_q.push_back(ev);
         1:       exp_b_q.push_back(ev);
         default: exp_c_q.push_back(ev);
      endcase
   endtask

   task automatic cmp(input string tag, input logic smo, input logic arm, input logic st,
                      input logic [7:0] cnt, input int qsize, input logic [10:0] e);
      if (qsize == 0) begin
         check({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
         check({tag, "_smOut"}, 32'(smo), 32'(e[10]));
         check({tag, "_armed"}, 32'(arm), 32'(e[9]));
         check({tag, "_sat"},   32'(st),  32'(e[8]));
         check({tag, "_cnt"},   32'(cnt), 32'(e[7:0]));
      end
   endtask

   task automatic compare_all();
      int sa, sb, sc;
      logic [10:0] ea, eb, ec;
      sa = exp_a_q.size(); sb = exp_b_q.size(); sc = exp_c_q.size();
      ea = (sa != 0) ? exp_a_q.pop_front() : '0;
      eb = (sb != 0) ? exp_b_q.pop_front() : '0;
      ec = (sc != 0) ? exp_c_q.pop_front() : '0;
      cmp("a", if_a.smOut, if_a.armed, if_a.sat, 8'(if_a.match_cnt), sa, ea);
      cmp("b", if_b.smOut, if_b.armed, if_b.sat, 8'(if_b.match_cnt), sb, eb);
      cmp("c", if_c.smOut, if_c.armed, if_c.sat, 8'(if_c.match_cnt), sc, ec);
   endtask

   // driver: apply one cycle of inputs, advance the model, check after the edge
   task automatic drive(input bit r, input bit e, input bit d, input bit c);
      rst = r; en = e; din = d; clr = c;
      for (int k = 0; k < NI; k++) model_step(k, r, e, d, c);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic send_bits(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) drive(1'b0, 1'b1, bits[i], 1'b0);
   endtask

   initial begin
      logic [15:0] t1_bits;
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1; en = 1'b0; din = 1'b0; clr = 1'b0;

      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check("reset_a_cnt", 32'(if_a.match_cnt), 32'd0);
      check("reset_a_armed", 32'(if_a.armed), 32'd0);

      // stream 1,0,1,1,0,1,1: hits after the 4th and 7th bit with overlap
      t1_bits = 16'b1011011;
      for (int i = 6; i >= 0; i--) begin
         drive(1'b0, 1'b1, t1_bits[i], 1'b0);
         if (i == 3) begin
            check("t1_a_smout_first", 32'(if_a.smOut), 32'd1);
            check("t1_a_armed_first", 32'(if_a.armed), 32'd1);
            check("t1_b_armed_first", 32'(if_b.armed), 32'd0);
         end
         if (i == 2) check("t1_a_smout_gap", 32'(if_a.smOut), 32'd0);
      end
      check("t1_a_smout_second", 32'(if_a.smOut), 32'd1);
      check("t1_a_cnt", 32'(if_a.match_cnt), 32'd2);
      check("t2_b_cnt", 32'(if_b.match_cnt), 32'd1);
      check("t4_b_stretched", 32'(if_b.smOut), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);

      // en=0 gaps with in toggling must not disturb the history
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      t1_bits = 16'b1011;
      for (int i = 3; i >= 0; i--) begin
         drive(1'b0, 1'b0, ~t1_bits[i], 1'b0);
         drive(1'b0, 1'b0, t1_bits[i], 1'b0);
         drive(1'b0, 1'b1, t1_bits[i], 1'b0);
      end
      check("t3_a_smout", 32'(if_a.smOut), 32'd1);
      check("t3_a_cnt", 32'(if_a.match_cnt), 32'd1);

      // reset during a stretched pulse of instance b
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      send_bits(16'b1011, 4);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check("t6_b_smout", 32'(if_b.smOut), 32'd0);
      check("t6_b_cnt", 32'(if_b.match_cnt), 32'd0);
      send_bits(16'b11, 2);
      check("t6_a_no_stale_match", 32'(if_a.match_cnt), 32'd0);

      // long overlapping 1011011... stream drives the counters into saturation
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 800; i++) drive(1'b0, 1'b1, (i % 3) != 1, 1'b0);
      check("t5_a_sat", 32'(if_a.sat), 32'd1);
      check("t5_a_cnt", 32'(if_a.match_cnt), 32'd255);
      check("t5_b_sat", 32'(if_b.sat), 32'd1);
      check("t5_b_cnt", 32'(if_b.match_cnt), 32'd3);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      check("t5_a_clr_cnt", 32'(if_a.match_cnt), 32'd0);
      check("t5_a_clr_sat", 32'(if_a.sat), 32'd0);

      // randomized traffic with occasional clear and reset
      for (int i = 0; i < 1500; i++) begin
         drive($urandom_range(0, 150) == 0, $urandom_range(0, 3) != 0,
               1'($urandom_range(0, 1)), $urandom_range(0, 40) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
